// File: rtl/servo_cmd_seq.sv
// servo_cmd_seq
// -------------
// Command sequencer that sits in front of the continuous-rotation servo PWM
// stage. Two raw push buttons are synchronized and debounced. Each rising
// edge of a debounced level becomes a one-cycle request. The FSM turns an
// accepted request into an open or close level command. That command is held
// for RUN_CYCLES, which sets the rotation distance. The FSM also tracks the
// mechanism position, so a request that matches the current position is
// dropped.
//
// Optional feature macro: SERVO_CMD_SETTLE_EN
//   defined   : after every completed move the FSM sits in SETTLE for
//               SETTLE_CYCLES cycles (commands low, busy high, requests
//               dropped) before returning to IDLE.
//   undefined : SETTLE, its counter and the SETTLE_CYCLES parameter are
//               compiled out; completion returns straight to IDLE.
//
// Handshake: there is no valid/ready traffic here. Requests are single-cycle
// pulses that are consumed only in IDLE; in any other state they are
// discarded, never queued.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   btn_open   in   raw open button, asynchronous, active high
//   btn_close  in   raw close button, asynchronous, active high
//   abort      in   synchronous, active high; cancels a move in progress
//   open       out  registered open command to the PWM stage
//   close      out  registered close command to the PWM stage
//   busy       out  high whenever the FSM is not in IDLE
//   done       out  one-cycle pulse when a move completes normally
//   is_open    out  position flag, 1 = open, 0 = closed
module servo_cmd_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter int unsigned RUN_CYCLES      = 32'd100000000
`ifdef SERVO_CMD_SETTLE_EN
  ,
  parameter int unsigned SETTLE_CYCLES   = 32'd20000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_open,
  input  logic btn_close,
  input  logic abort,
  output logic open,
  output logic close,
  output logic busy,
  output logic done,
  output logic is_open
);

  localparam logic [31:0] DB_LAST  = DEBOUNCE_CYCLES - 32'd1;
  localparam logic [31:0] RUN_LAST = RUN_CYCLES - 32'd1;
`ifdef SERVO_CMD_SETTLE_EN
  localparam logic [31:0] SETTLE_LAST = SETTLE_CYCLES - 32'd1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN_OPEN  = 2'd1,
    ST_RUN_CLOSE = 2'd2
`ifdef SERVO_CMD_SETTLE_EN
    ,
    ST_SETTLE    = 2'd3
`endif
  } state_e;

  // Bit 0 carries the open button, bit 1 carries the close button.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_prev_q, deb_prev_d;
  logic [1:0]       req_q, req_d;
  logic [1:0][31:0] db_cnt_q, db_cnt_d;

  state_e      state_q, state_d;
  logic [31:0] run_cnt_q, run_cnt_d;
`ifdef SERVO_CMD_SETTLE_EN
  logic [31:0] settle_cnt_q, settle_cnt_d;
`endif
  logic        is_open_q, is_open_d;
  logic        done_q, done_d;
  logic        open_q, open_d;
  logic        close_q, close_d;

  // ---------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer, debounce, rising-edge request
  // ---------------------------------------------------------------------
  always_comb begin
    sync1_d    = {btn_close, btn_open};
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    db_cnt_d   = db_cnt_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        // The new level must still differ on the cycle where the count
        // reaches its last value, so a pulse shorter than the window never
        // flips the debounced level.
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i]    = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 32'd1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
    // Only rising edges of the debounced level become requests.
    req_d = deb_q & ~deb_prev_q;
  end

  // ---------------------------------------------------------------------
  // FSM: state register (with all other flops)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      req_q        <= '0;
      db_cnt_q     <= '0;
      state_q      <= ST_IDLE;
      run_cnt_q    <= '0;
`ifdef SERVO_CMD_SETTLE_EN
      settle_cnt_q <= '0;
`endif
      is_open_q    <= 1'b0;
      done_q       <= 1'b0;
      open_q       <= 1'b0;
      close_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      req_q        <= req_d;
      db_cnt_q     <= db_cnt_d;
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
`ifdef SERVO_CMD_SETTLE_EN
      settle_cnt_q <= settle_cnt_d;
`endif
      is_open_q    <= is_open_d;
      done_q       <= done_d;
      open_q       <= open_d;
      close_q      <= close_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
`ifdef SERVO_CMD_SETTLE_EN
    settle_cnt_d = settle_cnt_q;
`endif
    is_open_d    = is_open_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Close is checked first, so when both requests arrive together the
        // one that moves the mechanism away from its current position wins.
        if (req_q[1] && is_open_q) begin
          state_d = ST_RUN_CLOSE;
        end else if (req_q[0] && !is_open_q) begin
          state_d = ST_RUN_OPEN;
        end
      end
      ST_RUN_OPEN, ST_RUN_CLOSE: begin
        if (abort) begin
          // Cancelled move: the position is left as it was, and no done.
          state_d   = ST_IDLE;
          run_cnt_d = '0;
        end else if (run_cnt_q == RUN_LAST) begin
          run_cnt_d = '0;
          is_open_d = ~is_open_q;
          done_d    = 1'b1;
`ifdef SERVO_CMD_SETTLE_EN
          state_d   = ST_SETTLE;
`else
          state_d   = ST_IDLE;
`endif
        end else begin
          run_cnt_d = run_cnt_q + 32'd1;
        end
      end
`ifdef SERVO_CMD_SETTLE_EN
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = ST_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 32'd1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. The commands are decoded from the next state and then
  // registered, so they change on the same edge as the state.
  // ---------------------------------------------------------------------
  always_comb begin
    open_d  = (state_d == ST_RUN_OPEN);
    close_d = (state_d == ST_RUN_CLOSE);
  end

  assign open    = open_q;
  assign close   = close_q;
  assign done    = done_q;
  assign is_open = is_open_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_servo_cmd_seq.sv
`timescale 1ns/1ps
module tb_servo_cmd_seq;

  localparam int DEB = 4;
  localparam int RUN = 10;
  localparam int SET = 5;
`ifdef SERVO_CMD_SETTLE_EN
  localparam bit SETTLE_ON = 1'b1;
`else
  localparam bit SETTLE_ON = 1'b0;
`endif
  localparam int SETTLE_LEN = SETTLE_ON ? SET : 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic btn_open, btn_close, abort;
  logic open, close, busy, done, is_open;

  always #5 clk = ~clk;

  servo_cmd_seq #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_CYCLES(RUN)
`ifdef SERVO_CMD_SETTLE_EN
    ,
    .SETTLE_CYCLES(SET)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_open(btn_open),
    .btn_close(btn_close),
    .abort(abort),
    .open(open),
    .close(close),
    .busy(busy),
    .done(done),
    .is_open(is_open)
  );

  int checks = 0;
  int errors = 0;
  bit model_open = 1'b0;   // reference position: 1 = open
  int both_seen = 0;

  always @(negedge clk) begin
    if (open === 1'b1 && close === 1'b1) both_seen++;
  end

  // observation results of one press window
  int obs_open_n, obs_close_n, obs_done_n, obs_busy_n;
  int obs_rise_at, obs_done_at;
  logic obs_busy_at_done, obs_isopen_at_done;

  // Driver: press the given buttons, release after 'hold' samples, and
  // record what the outputs do over 'window' samples. Called at a negedge.
  task automatic observe(input logic bo, input logic bc, input int hold, input int window);
    obs_open_n = 0; obs_close_n = 0; obs_done_n = 0; obs_busy_n = 0;
    obs_rise_at = -1; obs_done_at = -1;
    obs_busy_at_done = 1'bx; obs_isopen_at_done = 1'bx;
    btn_open = bo;
    btn_close = bc;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (open) obs_open_n++;
      if (close) obs_close_n++;
      if (busy) obs_busy_n++;
      if ((open || close) && obs_rise_at < 0) obs_rise_at = k;
      if (done) begin
        obs_done_n++;
        if (obs_done_at < 0) begin
          obs_done_at = k;
          obs_busy_at_done = busy;
          obs_isopen_at_done = is_open;
        end
      end
      if (k == hold) begin
        btn_open = 1'b0;
        btn_close = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (open !== 1'b0) begin errors++; $display("FAIL reset_open got %b want 0", open); end
    checks++; if (close !== 1'b0) begin errors++; $display("FAIL reset_close got %b want 0", close); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (is_open !== 1'b0) begin errors++; $display("FAIL reset_is_open got %b want 0", is_open); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glitch;
    int open_bad = 0;
    int busy_bad = 0;
    for (int r = 0; r < 4; r++) begin
      btn_open = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (open !== 1'b0) open_bad++;
        if (busy !== 1'b0) busy_bad++;
      end
      btn_open = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (open !== 1'b0) open_bad++;
        if (busy !== 1'b0) busy_bad++;
      end
    end
    repeat (12) begin
      @(negedge clk);
      if (open !== 1'b0) open_bad++;
      if (busy !== 1'b0) busy_bad++;
    end
    checks++; if (open_bad != 0) begin errors++; $display("FAIL glitch_open got %0d high samples want 0", open_bad); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL glitch_busy got %0d high samples want 0", busy_bad); end
    checks++; if (is_open !== model_open) begin errors++; $display("FAIL glitch_is_open got %b want %b", is_open, model_open); end
  endtask

  task automatic test_redundant;
    observe(1'b0, 1'b1, 8, 30);
    checks++; if (obs_close_n != 0) begin errors++; $display("FAIL redundant_close got %0d want 0", obs_close_n); end
    checks++; if (obs_busy_n != 0) begin errors++; $display("FAIL redundant_busy got %0d want 0", obs_busy_n); end
    checks++; if (obs_open_n != 0) begin errors++; $display("FAIL redundant_open got %0d want 0", obs_open_n); end
    checks++; if (is_open !== 1'b0) begin errors++; $display("FAIL redundant_is_open got %b want 0", is_open); end
  endtask

  task automatic test_open_move;
    observe(1'b1, 1'b0, 8, 35);
    model_open = 1'b1;
    checks++; if (obs_open_n != RUN) begin errors++; $display("FAIL move_open_len got %0d want %0d", obs_open_n, RUN); end
    checks++; if (obs_close_n != 0) begin errors++; $display("FAIL move_close_len got %0d want 0", obs_close_n); end
    checks++; if (obs_done_n != 1) begin errors++; $display("FAIL move_done_cnt got %0d want 1", obs_done_n); end
    checks++; if (obs_rise_at < DEB + 4 || obs_rise_at > DEB + 6) begin
      errors++; $display("FAIL move_latency got %0d want %0d..%0d", obs_rise_at, DEB + 4, DEB + 6); end
    checks++; if (obs_done_at != obs_rise_at + RUN) begin
      errors++; $display("FAIL move_done_at got %0d want %0d", obs_done_at, obs_rise_at + RUN); end
    checks++; if (obs_isopen_at_done !== 1'b1) begin errors++; $display("FAIL move_is_open_at_done got %b want 1", obs_isopen_at_done); end
    checks++; if (obs_busy_n != RUN + SETTLE_LEN) begin
      errors++; $display("FAIL move_busy_len got %0d want %0d", obs_busy_n, RUN + SETTLE_LEN); end
    checks++; if (obs_busy_at_done !== SETTLE_ON) begin errors++; $display("FAIL move_busy_at_done got %b want %b", obs_busy_at_done, SETTLE_ON); end
    checks++; if (is_open !== model_open) begin errors++; $display("FAIL move_is_open got %b want %b", is_open, model_open); end
  endtask

  task automatic test_abort;
    int seen_close = 0;
    int seen_open = 0;
    int seen_done = 0;
    int exp_close = model_open ? 5 : 0;
    btn_close = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (close) seen_close++;
      if (open) seen_open++;
      if (done) seen_done++;
      abort = 1'b0;
      if (close && seen_close == 5) abort = 1'b1;
      if (k == 8) btn_close = 1'b0;
    end
    abort = 1'b0;
    checks++; if (seen_close != exp_close) begin errors++; $display("FAIL abort_close_len got %0d want %0d", seen_close, exp_close); end
    checks++; if (seen_open != 0) begin errors++; $display("FAIL abort_open_len got %0d want 0", seen_open); end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_done got %0d want 0", seen_done); end
    checks++; if (is_open !== model_open) begin errors++; $display("FAIL abort_is_open got %b want %b", is_open, model_open); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int kind, hold, dir;
      logic bo, bc, sel;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      kind = $urandom_range(0, 3);
      sel = 1'($urandom_range(0, 1));
      bo = (kind == 0) || (kind == 2) || (kind == 3 && sel);
      bc = (kind == 1) || (kind == 2) || (kind == 3 && !sel);
      hold = (kind == 3) ? 2 : $urandom_range(7, 12);
      if (kind == 3) dir = 0;
      else if (bc && model_open) dir = 2;
      else if (bo && !model_open) dir = 1;
      else dir = 0;
      observe(bo, bc, hold, 35 + SETTLE_LEN);
      if (dir != 0) model_open = ~model_open;
      checks++; if (obs_open_n != ((dir == 1) ? RUN : 0)) begin
        errors++; $display("FAIL random_%0d_open got %0d want %0d", it, obs_open_n, (dir == 1) ? RUN : 0); end
      checks++; if (obs_close_n != ((dir == 2) ? RUN : 0)) begin
        errors++; $display("FAIL random_%0d_close got %0d want %0d", it, obs_close_n, (dir == 2) ? RUN : 0); end
      checks++; if (obs_done_n != ((dir != 0) ? 1 : 0)) begin
        errors++; $display("FAIL random_%0d_done got %0d want %0d", it, obs_done_n, (dir != 0) ? 1 : 0); end
      checks++; if (is_open !== model_open) begin
        errors++; $display("FAIL random_%0d_is_open got %b want %b", it, is_open, model_open); end
    end
  endtask

  task automatic test_reset_mid_move;
    int seen = 0;
    btn_open = !model_open;
    btn_close = model_open;
    for (int k = 1; k <= 30 && seen < 3; k++) begin
      @(negedge clk);
      if (open || close) seen++;
    end
    checks++; if (seen != 3) begin errors++; $display("FAIL midreset_move_start got %0d want 3", seen); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (open !== 1'b0) begin errors++; $display("FAIL midreset_open got %b want 0", open); end
    checks++; if (close !== 1'b0) begin errors++; $display("FAIL midreset_close got %b want 0", close); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (is_open !== 1'b0) begin errors++; $display("FAIL midreset_is_open got %b want 0", is_open); end
    @(negedge clk);
    btn_open = 1'b0;
    btn_close = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_open = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_both;
    observe(1'b1, 1'b1, 8, 35);
    model_open = 1'b1;
    checks++; if (obs_open_n != RUN) begin errors++; $display("FAIL both_open got %0d want %0d", obs_open_n, RUN); end
    checks++; if (obs_close_n != 0) begin errors++; $display("FAIL both_close got %0d want 0", obs_close_n); end
    checks++; if (obs_done_n != 1) begin errors++; $display("FAIL both_done got %0d want 1", obs_done_n); end
    checks++; if (is_open !== model_open) begin errors++; $display("FAIL both_is_open got %b want %b", is_open, model_open); end
  endtask

  // A first move, then the opposite button pressed so that its request lands
  // in the cycle right after done.
  task automatic test_settle;
    logic first_open;
    logic [63:0] busy_hist;
    int open_n = 0;
    int close_n = 0;
    int done_n = 0;
    int done_at = -1;
    int second_rise = -1;
    int exp_first, exp_second, exp_second_rise;
    first_open = !model_open;
    busy_hist = '0;
    btn_open = first_open;
    btn_close = !first_open;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      busy_hist[k] = busy;
      if (open) open_n++;
      if (close) close_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (done_at >= 0 && k > done_at && second_rise < 0 && (first_open ? close : open)) second_rise = k;
      if (k == 8) begin btn_open = 1'b0; btn_close = 1'b0; end
      if (k == RUN + 2) begin btn_open = !first_open; btn_close = first_open; end
      if (k == RUN + 10) begin btn_open = 1'b0; btn_close = 1'b0; end
    end
    exp_first = RUN;
    exp_second = SETTLE_ON ? 0 : RUN;
    checks++; if ((first_open ? open_n : close_n) != exp_first) begin
      errors++; $display("FAIL settle_first_len got %0d want %0d", first_open ? open_n : close_n, exp_first); end
    checks++; if ((first_open ? close_n : open_n) != exp_second) begin
      errors++; $display("FAIL settle_second_len got %0d want %0d", first_open ? close_n : open_n, exp_second); end
    checks++; if (done_n != (SETTLE_ON ? 1 : 2)) begin
      errors++; $display("FAIL settle_done_cnt got %0d want %0d", done_n, SETTLE_ON ? 1 : 2); end
    checks++; if (done_at < 1 || done_at + SET > 63) begin
      errors++; $display("FAIL settle_done_seen got %0d want 1..%0d", done_at, 63 - SET);
    end else begin
      exp_second_rise = SETTLE_ON ? -1 : done_at + 2;
      checks++; if (second_rise != exp_second_rise) begin
        errors++; $display("FAIL settle_second_rise got %0d want %0d", second_rise, exp_second_rise); end
      checks++; if (busy_hist[done_at] !== SETTLE_ON) begin
        errors++; $display("FAIL settle_busy_at_done got %b want %b", busy_hist[done_at], SETTLE_ON); end
      checks++; if (busy_hist[done_at + SET - 1] !== 1'b1) begin
        errors++; $display("FAIL settle_busy_before_end got %b want 1", busy_hist[done_at + SET - 1]); end
      checks++; if (busy_hist[done_at + SET] !== !SETTLE_ON) begin
        errors++; $display("FAIL settle_busy_after_end got %b want %b", busy_hist[done_at + SET], !SETTLE_ON); end
    end
    model_open = SETTLE_ON ? first_open : !first_open;
    checks++; if (is_open !== model_open) begin errors++; $display("FAIL settle_is_open got %b want %b", is_open, model_open); end
  endtask

  task automatic test_exclusive;
    checks++; if (both_seen != 0) begin errors++; $display("FAIL exclusive_cmds got %0d overlap samples want 0", both_seen); end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_open = 1'b0;
    btn_close = 1'b0;
    abort = 1'b0;
    test_reset;
    test_glitch;
    test_redundant;
    test_open_move;
    test_abort;
    test_random;
    test_reset_mid_move;
    test_both;
    test_settle;
    test_exclusive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
